// File: rtl/nios2_pio_led_out_if.sv
// ============================================================================
// Module   : nios2_pio_led_out_if
// Brief    : Avalon-MM slave bus bundle for the LED output PIO.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface nios2_pio_led_out_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

`default_nettype wire

// File: rtl/nios2_pio_led_out.sv
// ============================================================================
// Module   : nios2_pio_led_out
// Brief    : Avalon-MM LED output PIO with set/clear, optional timed pulse
//            overlay enabled by macro PIO_OUT_PULSE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nios2_pio_led_out #(
  parameter int              WIDTH           = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
  parameter logic [15:0]     PULSE_RESET_LEN = 16'd50000
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  nios2_pio_led_out_if.slave    bus,
  output logic [WIDTH-1:0]      out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  logic             wr;
  logic [WIDTH-1:0] wbits;
  logic [WIDTH-1:0] data;
  logic [31:0]      rd_next;
  logic             unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign wbits        = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
    end else if (wr) begin
      case (bus.address)
        ADDR_DATA:     data <= wbits;
        ADDR_OUTSET:   data <= data | wbits;
        ADDR_OUTCLEAR: data <= data & ~wbits;
        default:       data <= data;
      endcase
    end
  end

`ifdef PIO_OUT_PULSE_EN
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
  localparam logic [2:0] ADDR_PULSE     = 3'd2;
  localparam logic [2:0] ADDR_STATUS    = 3'd3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           state;
  logic [15:0]      pulse_len;
  logic [15:0]      cnt;
  logic [WIDTH-1:0] pmask;
  logic             pulse_go;

  // Zero-data writes and writes while the length is zero are dropped entirely.
  assign pulse_go = wr && (bus.address == ADDR_PULSE) && (wbits != '0) && (pulse_len != 16'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_len <= PULSE_RESET_LEN;
    end else if (wr && (bus.address == ADDR_PULSE_LEN)) begin
      pulse_len <= bus.writedata[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 16'd0;
      pmask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pulse_go) begin
            pmask <= wbits;
            cnt   <= pulse_len;
            state <= COUNT;
          end
        end
        COUNT: begin
          // A retrigger wins over expiry landing in the same cycle.
          if (pulse_go) begin
            pmask <= pmask | wbits;
            cnt   <= pulse_len;
          end else if (cnt == 16'd1) begin
            pmask <= '0;
            cnt   <= 16'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 16'd0;
          pmask <= '0;
        end
      endcase
    end
  end

  assign out_port = data | pmask;
`else
  assign out_port = data;
`endif

  always_comb begin
    rd_next = '0;
    case (bus.address)
      ADDR_DATA:      rd_next[WIDTH-1:0] = data;
`ifdef PIO_OUT_PULSE_EN
      ADDR_PULSE_LEN: rd_next[15:0]      = pulse_len;
      ADDR_STATUS:    rd_next[0]         = (state == COUNT);
`endif
      default:        rd_next            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= 32'd0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nios2_pio_led_out.sv
// ============================================================================
// Module   : tb_nios2_pio_led_out
// Brief    : Directed scoreboard bench for nios2_pio_led_out (both builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nios2_pio_led_out;

  localparam int WIDTH = 10;

  typedef struct {
    string       tag;
    bit          is_rd;
    logic [31:0] val;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] out_port;
  exp_t             sb[$];
  int               n_checks = 0;
  int               n_fail = 0;

  nios2_pio_led_out_if bus ();

  nios2_pio_led_out #(
    .WIDTH           (WIDTH),
    .RESET_VALUE     (10'h000),
    .PULSE_RESET_LEN (16'd50000)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] v);
    sb.push_back('{tag: tag, is_rd: 1'b0, val: v});
  endtask

  task automatic expect_rd(input string tag, input logic [31:0] v);
    sb.push_back('{tag: tag, is_rd: 1'b1, val: v});
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
    end else begin
      e   = sb.pop_front();
      obs = e.is_rd ? bus.readdata : {{(32-WIDTH){1'b0}}, out_port};
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a);
    bus.address = a;
    tick();
  endtask

  initial begin
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    #1;
    expect_out("reset_out", 32'h0);        check();
    expect_rd ("reset_rd", 32'h0);         check();
    tick();
    reset_n = 1'b1;

    expect_out("pre_write_out", 32'h0);    check();
    bus_write(3'd0, 32'h0000_03FF);
    expect_out("data_3ff_out", 32'h3FF);   check();
    bus_read(3'd0);
    expect_rd ("data_3ff_rd", 32'h3FF);    check();

    bus_write(3'd0, 32'h0000_00F0);
    bus_write(3'd4, 32'h0000_0003);
    expect_out("outset_out", 32'h0F3);     check();
    bus_write(3'd5, 32'h0000_0030);
    expect_out("outclear_out", 32'h0C3);   check();
    bus_read(3'd0);
    expect_rd ("outclear_rd", 32'h0C3);    check();

    bus_read(3'd4);  expect_rd("outset_rd0", 32'h0);   check();
    bus_read(3'd6);  expect_rd("rsvd6_rd0", 32'h0);    check();
    bus_read(3'd7);  expect_rd("rsvd7_rd0", 32'h0);    check();

    // Non-write cycles must leave DATA alone.
    bus.address = 3'd0; bus.writedata = 32'h155; bus.chipselect = 1'b0; bus.write_n = 1'b0;
    tick();
    bus.chipselect = 1'b1; bus.write_n = 1'b1;
    tick();
    bus.chipselect = 1'b0;
    expect_out("no_write_out", 32'h0C3);   check();

`ifdef PIO_OUT_PULSE_EN
    bus_write(3'd0, 32'h0);
    bus_write(3'd1, 32'd4);
    bus_read(3'd1);  expect_rd("plen_rd", 32'd4);      check();

    bus_write(3'd2, 32'h001);
    bus.address = 3'd3;
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("pulse_hi%0d", i), 32'h001); check();
      if (i > 0) begin
        expect_rd($sformatf("status_hi%0d", i), 32'h1); check();
      end
      tick();
    end
    expect_out("pulse_end_out", 32'h0);    check();
    expect_rd ("status_last", 32'h1);      check();
    tick();
    expect_rd ("status_idle", 32'h0);      check();

    bus_write(3'd2, 32'h001);
    expect_out("retrig_hi1", 32'h001);     check();
    tick();
    expect_out("retrig_hi2", 32'h001);     check();
    tick();
    expect_out("retrig_hi3", 32'h001);     check();
    bus_write(3'd2, 32'h002);
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("retrig_or%0d", i), 32'h003); check();
      tick();
    end
    expect_out("retrig_end", 32'h0);      check();

    bus_write(3'd1, 32'd0);
    bus_write(3'd2, 32'h001);
    expect_out("len0_out", 32'h0);        check();
    bus_read(3'd3); expect_rd("len0_status", 32'h0); check();
    bus_write(3'd1, 32'd4);
    bus_write(3'd2, 32'h000);
    expect_out("zero_pulse_out", 32'h0);  check();
    bus_read(3'd3); expect_rd("zero_status", 32'h0); check();

    bus_write(3'd0, 32'h100);
    bus_write(3'd2, 32'h001);
    expect_out("data_plus_pulse", 32'h101); check();
    bus_write(3'd0, 32'h200);
    expect_out("data_keeps_pmask", 32'h201); check();
    reset_n = 1'b0;
    #1;
    expect_out("midpulse_reset_out", 32'h0); check();
    expect_rd ("midpulse_reset_rd", 32'h0);  check();
    tick();
    reset_n = 1'b1;
    bus_read(3'd3); expect_rd("post_reset_status", 32'h0);   check();
    bus_read(3'd1); expect_rd("post_reset_plen", 32'd50000); check();
    expect_out("post_reset_out", 32'h0);     check();
`else
    bus_write(3'd1, 32'hFFFF);
    bus_write(3'd2, 32'h3FF);
    bus_write(3'd3, 32'h3FF);
    expect_out("nopulse_out", 32'h0C3);   check();
    bus_read(3'd1); expect_rd("nopulse_rd1", 32'h0); check();
    bus_read(3'd2); expect_rd("nopulse_rd2", 32'h0); check();
    bus_read(3'd3); expect_rd("nopulse_rd3", 32'h0); check();
    reset_n = 1'b0;
    #1;
    expect_out("reset_again_out", 32'h0); check();
    expect_rd ("reset_again_rd", 32'h0);  check();
    tick();
    reset_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
